// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the MIPS D-stage hazard logic: opcode/funct constants,
// Tuse levels, Tnew classes, MDU start classes, the decoded-instruction record
// and the per-stage hazard record carried through E, M and W.
// Intended for reuse by both the stall controller and forwarding logic.
// -----------------------------------------------------------------------------
package hazard_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // SPECIAL funct codes
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    // Tuse: stage distance (from D) at which a source operand is consumed
    localparam logic [1:0] TUSE_0 = 2'd0;   // branch/jump compare in D
    localparam logic [1:0] TUSE_1 = 2'd1;   // ALU/MDU operand in E
    localparam logic [1:0] TUSE_2 = 2'd2;   // store data in M

    // Tnew class on entering E; the load value is set by LOAD_TNEW in the top
    typedef enum logic [1:0] {
        TNEW_K0   = 2'd0,
        TNEW_K1   = 2'd1,
        TNEW_LOAD = 2'd2
    } tnew_kind_t;

    typedef enum logic [1:0] {
        MDU_NONE = 2'd0,
        MDU_MULT = 2'd1,
        MDU_DIV  = 2'd2
    } mdu_start_t;

    // Stage Tnew field width; LOAD_TNEW must fit (LOAD_TNEW <= 15)
    localparam int TNEW_MAX_W = 4;

    typedef struct packed {
        logic [4:0]            dst;
        logic [TNEW_MAX_W-1:0] tnew;
        mdu_start_t            mdu_start;
    } stage_rec_t;

    typedef struct packed {
        logic [4:0]  rs;        // 0 when rs is not a source
        logic [4:0]  rt;        // 0 when rt is not a source
        logic [1:0]  tuse_rs;
        logic [1:0]  tuse_rt;
        logic [4:0]  dst;       // 0 when no destination
        tnew_kind_t  tnew;
        logic        mdu_class; // touches HI/LO or the MDU
        mdu_start_t  mdu_start;
    } dec_rec_t;

endpackage

// File: rtl/hazard_unit_decode.sv
// -----------------------------------------------------------------------------
// hazard_decode
// Combinational decode of the D-stage instruction into the fields the hazard
// logic needs. Unused source fields are reported as register 0, which the
// compare logic never treats as a hazard. Unknown encodings decode as nop.
//
// Ports:
//   i_instr  in  32  instruction word
//   o_dec    out     decoded record {rs, rt, tuse_rs, tuse_rt, dst, tnew,
//                    mdu_class, mdu_start}
// -----------------------------------------------------------------------------
module hazard_decode
    import hazard_pkg::*;
(
    input  logic [31:0] i_instr,
    output dec_rec_t    o_dec
);

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic [4:0] w_rd;
    logic       w_unused;

    assign w_op     = i_instr[31:26];
    assign w_rs     = i_instr[25:21];
    assign w_rt     = i_instr[20:16];
    assign w_rd     = i_instr[15:11];
    assign w_funct  = i_instr[5:0];
    assign w_unused = ^i_instr[10:6];

    always_comb begin
        o_dec = '0;
        o_dec.tnew      = TNEW_K0;
        o_dec.mdu_start = MDU_NONE;
        unique case (w_op)
            OP_SPECIAL: begin
                unique case (w_funct)
                    FN_ADDU, FN_SUBU: begin
                        o_dec.rs      = w_rs;
                        o_dec.rt      = w_rt;
                        o_dec.tuse_rs = TUSE_1;
                        o_dec.tuse_rt = TUSE_1;
                        o_dec.dst     = w_rd;
                        o_dec.tnew    = TNEW_K1;
                    end
                    FN_JR: begin
                        o_dec.rs      = w_rs;
                        o_dec.tuse_rs = TUSE_0;
                    end
                    FN_MULT, FN_MULTU: begin
                        o_dec.rs        = w_rs;
                        o_dec.rt        = w_rt;
                        o_dec.tuse_rs   = TUSE_1;
                        o_dec.tuse_rt   = TUSE_1;
                        o_dec.mdu_class = 1'b1;
                        o_dec.mdu_start = MDU_MULT;
                    end
                    FN_DIV, FN_DIVU: begin
                        o_dec.rs        = w_rs;
                        o_dec.rt        = w_rt;
                        o_dec.tuse_rs   = TUSE_1;
                        o_dec.tuse_rt   = TUSE_1;
                        o_dec.mdu_class = 1'b1;
                        o_dec.mdu_start = MDU_DIV;
                    end
                    FN_MFHI, FN_MFLO: begin
                        o_dec.dst       = w_rd;
                        o_dec.tnew      = TNEW_K1;
                        o_dec.mdu_class = 1'b1;
                    end
                    FN_MTHI, FN_MTLO: begin
                        o_dec.rs        = w_rs;
                        o_dec.tuse_rs   = TUSE_1;
                        o_dec.mdu_class = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_ORI, OP_LUI: begin
                o_dec.rs      = w_rs;
                o_dec.tuse_rs = TUSE_1;
                o_dec.dst     = w_rt;
                o_dec.tnew    = TNEW_K1;
            end
            OP_LW, OP_LH, OP_LB: begin
                o_dec.rs      = w_rs;
                o_dec.tuse_rs = TUSE_1;
                o_dec.dst     = w_rt;
                o_dec.tnew    = TNEW_LOAD;
            end
            OP_SW, OP_SH, OP_SB: begin
                o_dec.rs      = w_rs;
                o_dec.rt      = w_rt;
                o_dec.tuse_rs = TUSE_1;
                o_dec.tuse_rt = TUSE_2;
            end
            OP_BEQ, OP_BNE: begin
                o_dec.rs      = w_rs;
                o_dec.rt      = w_rt;
                o_dec.tuse_rs = TUSE_0;
                o_dec.tuse_rt = TUSE_0;
            end
            OP_JAL: begin
                o_dec.dst  = 5'd31;
                o_dec.tnew = TNEW_K0;
            end
            default: ;  // j and unknown opcodes: no sources, no destination
        endcase
    end

endmodule

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
// Tuse/Tnew stall controller for a five-stage MIPS pipeline with a multi-cycle
// multiply/divide unit. Tracks {dst, tnew, mdu_start} for the E, M and W stages
// internally, compares them against the D-stage sources and runs an MDU busy
// countdown. Drives the PC/IF-ID freeze and the D/E bubble.
//
// Parameters:
//   MULT_CYCLES  busy cycles after mult/multu enters E (>= 1)
//   DIV_CYCLES   busy cycles after div/divu enters E (>= 1)
//   LOAD_TNEW    Tnew of loads on entering E (2..15)
//
// Ports:
//   clk            in   1   rising-edge clock
//   rst_n          in   1   asynchronous active-low reset
//   instr_d        in   32  instruction in D
//   valid_d        in   1   instr_d is real; 0 treats D as nop
//   stall_d        out  1   hold PC and IF/ID
//   flush_e        out  1   bubble into D/E (always equals stall_d)
//   mdu_busy       out  1   registered: MDU countdown non-zero
//   stall_cnt      out  32  (HAZARD_STATS_EN only) stall_d cycle count
//   mdu_stall_cnt  out  32  (HAZARD_STATS_EN only) MDU-stall cycle count
//
// Optional feature macro: HAZARD_STATS_EN adds the two statistics counters.
// Stall behaviour does not depend on it.
// -----------------------------------------------------------------------------
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int LOAD_TNEW   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_d,
    input  logic        valid_d,
    output logic        stall_d,
    output logic        flush_e,
    output logic        mdu_busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] mdu_stall_cnt
`endif
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [TNEW_MAX_W-1:0] TNEW_ONE  = TNEW_MAX_W'(1);
    localparam logic [TNEW_MAX_W-1:0] TNEW_LD   = TNEW_MAX_W'(LOAD_TNEW);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_MULT  = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0]      CNT_DIV   = CNT_W'(DIV_CYCLES);

    dec_rec_t         w_dec;
    stage_rec_t       w_dec_rec;
    stage_rec_t       r_stage_e;
    stage_rec_t       r_stage_m;
    stage_rec_t       r_stage_w;
    logic [CNT_W-1:0] r_mdu_cnt;
    logic [CNT_W-1:0] w_mdu_cnt_next;
    logic             r_mdu_busy;
    logic             w_data_stall;
    logic             w_mdu_stall;
    logic             w_stall;

    // Advance one stage: Tnew counts down and saturates at 0
    function automatic stage_rec_t age_rec(input stage_rec_t s);
        stage_rec_t r;
        r = s;
        if (s.tnew != '0) begin
            r.tnew = s.tnew - TNEW_ONE;
        end
        return r;
    endfunction

    // Producer in stage s blocks a source whose value is needed in tuse
    // cycles while the result is still tnew cycles away
    function automatic logic src_hazard(input stage_rec_t s,
                                        input logic [4:0] src,
                                        input logic [1:0] tuse);
        return (s.dst != 5'd0) && (s.dst == src) && (s.tnew > {2'b00, tuse});
    endfunction

    hazard_decode u_decode (
        .i_instr (instr_d),
        .o_dec   (w_dec)
    );

    always_comb begin
        w_dec_rec.dst       = w_dec.dst;
        w_dec_rec.mdu_start = w_dec.mdu_start;
        unique case (w_dec.tnew)
            TNEW_K1:   w_dec_rec.tnew = TNEW_ONE;
            TNEW_LOAD: w_dec_rec.tnew = TNEW_LD;
            default:   w_dec_rec.tnew = '0;
        endcase
    end

    always_comb begin
        w_data_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            stage_rec_t s;
            s = (i == 0) ? r_stage_e : ((i == 1) ? r_stage_m : r_stage_w);
            if (src_hazard(s, w_dec.rs, w_dec.tuse_rs) ||
                src_hazard(s, w_dec.rt, w_dec.tuse_rt)) begin
                w_data_stall = 1'b1;
            end
        end
    end

    // A mult/div sitting in E has not loaded the counter yet, so it must
    // block HI/LO users on its own
    assign w_mdu_stall = w_dec.mdu_class &&
                         (r_mdu_busy || (r_stage_e.mdu_start != MDU_NONE));

    assign w_stall  = valid_d && (w_data_stall || w_mdu_stall);
    assign stall_d  = w_stall;
    assign flush_e  = w_stall;
    assign mdu_busy = r_mdu_busy;

    always_comb begin
        w_mdu_cnt_next = r_mdu_cnt;
        if (r_stage_e.mdu_start == MDU_MULT) begin
            w_mdu_cnt_next = CNT_MULT;
        end else if (r_stage_e.mdu_start == MDU_DIV) begin
            w_mdu_cnt_next = CNT_DIV;
        end else if (r_mdu_cnt != '0) begin
            w_mdu_cnt_next = r_mdu_cnt - CNT_ONE;
        end
    end

    // D -> E -> M -> W stage shift and MDU countdown
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage_e  <= '0;
            r_stage_m  <= '0;
            r_stage_w  <= '0;
            r_mdu_cnt  <= '0;
            r_mdu_busy <= 1'b0;
        end else begin
            r_stage_e  <= (w_stall || !valid_d) ? '0 : w_dec_rec;
            r_stage_m  <= age_rec(r_stage_e);
            r_stage_w  <= age_rec(r_stage_m);
            r_mdu_cnt  <= w_mdu_cnt_next;
            r_mdu_busy <= (w_mdu_cnt_next != '0);
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_mdu_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt     <= '0;
            r_mdu_stall_cnt <= '0;
        end else begin
            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (valid_d && w_mdu_stall) begin
                r_mdu_stall_cnt <= r_mdu_stall_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt     = r_stall_cnt;
    assign mdu_stall_cnt = r_mdu_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
// Scoreboard bench for hazard_unit. The driver issues instructions into D
// (holding each while stalled), predicts stall/bubble/busy from a timeline
// model of producers and MDU occupancy, and queues the prediction. A monitor
// on the falling edge pops and compares. Directed sequences queue their
// end-to-end results for the same monitor. Optional HAZARD_STATS_EN build
// also checks the statistics counters.
// -----------------------------------------------------------------------------
module tb_hazard_unit;

    localparam int MC = 5;
    localparam int DC = 10;
    localparam int LT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr_d = '0;
    logic        valid_d = 1'b0;
    logic        stall_d;
    logic        flush_e;
    logic        mdu_busy;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] mdu_stall_cnt;
`endif

    always #5 clk = ~clk;

    hazard_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .LOAD_TNEW(LT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .instr_d  (instr_d),
        .valid_d  (valid_d),
        .stall_d  (stall_d),
        .flush_e  (flush_e),
        .mdu_busy (mdu_busy)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cnt     (stall_cnt),
        .mdu_stall_cnt (mdu_stall_cnt)
`endif
    );

    typedef enum int {
        K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_LH, K_LB, K_SW, K_SH, K_SB,
        K_BEQ, K_BNE, K_J, K_JAL, K_JR, K_MULT, K_MULTU, K_DIV, K_DIVU,
        K_MFHI, K_MFLO, K_MTHI, K_MTLO, K_NOP
    } kind_t;

    // Sources s1/s2 with their Tuse (-1 = none), destination, Tnew, HI/LO user,
    // MDU occupancy started by this instruction
    typedef struct {
        int s1; int t1; int s2; int t2; int dst; int tnew; bit mduc; int mdun;
    } mp_t;

    typedef struct { logic stall; logic busy; } exp_t;
    typedef struct { string name; longint act; longint exp; } dir_t;
    typedef struct { int dst; int tnew; int ce; } prod_t;

    exp_t   exp_q[$];
    dir_t   dir_q[$];
    prod_t  hist[$];
    int     tests = 0;
    int     fails = 0;
    int     busy_seen = 0;
    int     cyc = 0;
    int     mdu_ce = -1000;
    int     mdu_n = 0;
    longint exp_stall_tot = 0;
    longint exp_mdu_tot = 0;

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                          input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt);
        return {op, 5'(rs), 5'(rt), 16'h0001};
    endfunction

    function automatic logic [31:0] encode(input kind_t k, input int rs, input int rt,
                                           input int rd);
        case (k)
            K_ADDU:  return rtype(rs, rt, rd, 6'h21);
            K_SUBU:  return rtype(rs, rt, rd, 6'h23);
            K_ORI:   return itype(6'h0D, rs, rt);
            K_LUI:   return itype(6'h0F, rs, rt);
            K_LW:    return itype(6'h23, rs, rt);
            K_LH:    return itype(6'h21, rs, rt);
            K_LB:    return itype(6'h20, rs, rt);
            K_SW:    return itype(6'h2B, rs, rt);
            K_SH:    return itype(6'h29, rs, rt);
            K_SB:    return itype(6'h28, rs, rt);
            K_BEQ:   return itype(6'h04, rs, rt);
            K_BNE:   return itype(6'h05, rs, rt);
            K_J:     return {6'h02, 26'h0000040};
            K_JAL:   return {6'h03, 26'h0000040};
            K_JR:    return rtype(rs, 0, 0, 6'h08);
            K_MULT:  return rtype(rs, rt, 0, 6'h18);
            K_MULTU: return rtype(rs, rt, 0, 6'h19);
            K_DIV:   return rtype(rs, rt, 0, 6'h1A);
            K_DIVU:  return rtype(rs, rt, 0, 6'h1B);
            K_MFHI:  return rtype(0, 0, rd, 6'h10);
            K_MFLO:  return rtype(0, 0, rd, 6'h12);
            K_MTHI:  return rtype(rs, 0, 0, 6'h11);
            K_MTLO:  return rtype(rs, 0, 0, 6'h13);
            default: return {6'h3F, 5'(rs), 5'(rt), 16'h0000};
        endcase
    endfunction

    function automatic mp_t props(input kind_t k, input int rs, input int rt, input int rd);
        mp_t p;
        p = '{s1: -1, t1: 0, s2: -1, t2: 0, dst: 0, tnew: 0, mduc: 1'b0, mdun: 0};
        case (k)
            K_ADDU, K_SUBU: p = '{rs, 1, rt, 1, rd, 1, 1'b0, 0};
            K_ORI, K_LUI:   p = '{rs, 1, -1, 0, rt, 1, 1'b0, 0};
            K_LW, K_LH, K_LB: p = '{rs, 1, -1, 0, rt, LT, 1'b0, 0};
            K_SW, K_SH, K_SB: p = '{rs, 1, rt, 2, 0, 0, 1'b0, 0};
            K_BEQ, K_BNE:   p = '{rs, 0, rt, 0, 0, 0, 1'b0, 0};
            K_JAL:          p.dst = 31;
            K_JR:           p = '{rs, 0, -1, 0, 0, 0, 1'b0, 0};
            K_MULT, K_MULTU: p = '{rs, 1, rt, 1, 0, 0, 1'b1, MC};
            K_DIV, K_DIVU:  p = '{rs, 1, rt, 1, 0, 0, 1'b1, DC};
            K_MFHI, K_MFLO: p = '{-1, 0, -1, 0, rd, 1, 1'b1, 0};
            K_MTHI, K_MTLO: p = '{rs, 1, -1, 0, 0, 0, 1'b1, 0};
            default: ;
        endcase
        return p;
    endfunction

    // Is the value for register src still further away than it is needed?
    function automatic bit late(input int src, input int tuse);
        foreach (hist[i]) begin
            int age;
            int rem;
            age = cyc - hist[i].ce;
            if (age < 0 || age > 2) continue;
            rem = hist[i].tnew - age;
            if (rem < 0) rem = 0;
            if (src > 0 && hist[i].dst == src && rem > tuse) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic drive_cycle(input logic [31:0] ins, input logic v, input mp_t p,
                               output bit stalled);
        bit ds;
        bit ms;
        bit busy;
        bit st;
        instr_d = ins;
        valid_d = v;
        busy = (cyc > mdu_ce) && (cyc <= mdu_ce + mdu_n);
        ds = late(p.s1, p.t1) || late(p.s2, p.t2);
        ms = p.mduc && (busy || (mdu_ce == cyc));
        st = v && (ds || ms);
        exp_q.push_back('{stall: st, busy: busy});
        exp_stall_tot += st;
        exp_mdu_tot += (v && ms);
        @(posedge clk);
        if (v && !st) begin
            hist.push_back('{dst: p.dst, tnew: p.tnew, ce: cyc + 1});
            if (p.mdun > 0) begin
                mdu_ce = cyc + 1;
                mdu_n = p.mdun;
            end
        end
        while (hist.size() > 4) void'(hist.pop_front());
        cyc++;
        #1;
        stalled = st;
    endtask

    task automatic idle(input int n);
        bit s;
        for (int i = 0; i < n; i++) drive_cycle(32'h0, 1'b0, props(K_NOP, 0, 0, 0), s);
    endtask

    task automatic issue(input kind_t k, input int rs, input int rt, input int rd,
                         output int nstall);
        bit s;
        int guard;
        nstall = 0;
        guard = 0;
        do begin
            drive_cycle(encode(k, rs, rt, rd), 1'b1, props(k, rs, rt, rd), s);
            if (s) nstall++;
            guard++;
        end while (s && guard < 40);
        if (s) dir_q.push_back('{"issue_timeout", longint'(guard), 0});
    endtask

    task automatic expect_dir(input string name, input longint act, input longint exp);
        dir_q.push_back('{name, act, exp});
    endtask

    // Monitor: the only place comparisons are made and counted
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            tests += 3;
            if (stall_d !== e.stall) begin
                fails++;
                $display("FAIL stall_d cyc=%0d: got %b expected %b", cyc, stall_d, e.stall);
            end
            if (flush_e !== e.stall) begin
                fails++;
                $display("FAIL flush_e cyc=%0d: got %b expected %b", cyc, flush_e, e.stall);
            end
            if (mdu_busy !== e.busy) begin
                fails++;
                $display("FAIL mdu_busy cyc=%0d: got %b expected %b", cyc, mdu_busy, e.busy);
            end
            if (mdu_busy === 1'b1) busy_seen++;
        end
        while (dir_q.size() != 0) begin
            dir_t d;
            d = dir_q.pop_front();
            tests++;
            if (d.act != d.exp) begin
                fails++;
                $display("FAIL %s: got %0d expected %0d", d.name, d.act, d.exp);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int b0;
        repeat (3) @(posedge clk);
        #1;
        expect_dir("reset_mdu_busy", mdu_busy, 0);
        expect_dir("reset_stall_d", stall_d, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_dir("post_reset_flush_e", flush_e, 0);
        idle(2);

        // Load-use into ALU and into branch
        issue(K_LW, 0, 8, 0, n);
        issue(K_ADDU, 8, 8, 9, n);
        expect_dir("lw_addu_stalls", n, LT - 1);
        idle(4);
        issue(K_LW, 0, 8, 0, n);
        issue(K_BEQ, 8, 0, 0, n);
        expect_dir("lw_beq_stalls", n, LT);
        idle(4);

        // ALU result into jr; register 0 never a hazard
        issue(K_ORI, 0, 5, 0, n);
        issue(K_JR, 5, 0, 0, n);
        expect_dir("ori_jr_stalls", n, 1);
        idle(4);
        issue(K_ORI, 0, 0, 0, n);
        issue(K_JR, 0, 0, 0, n);
        expect_dir("ori_jr_r0_stalls", n, 0);
        idle(4);

        // MDU occupancy
        b0 = busy_seen;
        issue(K_MULT, 1, 2, 0, n);
        issue(K_MFLO, 0, 0, 3, n);
        expect_dir("mult_mflo_stalls", n, MC + 1);
        idle(3);
        expect_dir("mult_busy_cycles", busy_seen - b0, MC);
        issue(K_DIV, 1, 2, 0, n);
        issue(K_MFLO, 0, 0, 3, n);
        expect_dir("div_mflo_stalls", n, DC + 1);
        idle(2);

        // Back-to-back mult allowed once the counter drains
        issue(K_MULT, 1, 2, 0, n);
        issue(K_MULTU, 3, 4, 0, n);
        expect_dir("mult_mult_stalls", n, MC + 1);
        idle(MC + 2);

        // Reset while the MDU is busy
        issue(K_DIV, 1, 2, 0, n);
        idle(2);
        #2;
        rst_n = 1'b0;
        #1;
        expect_dir("midop_reset_busy", mdu_busy, 0);
        expect_dir("midop_reset_stall", stall_d, 0);
        hist.delete();
        mdu_ce = -1000;
        exp_stall_tot = 0;
        exp_mdu_tot = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(K_MFHI, 0, 0, 4, n);
        expect_dir("mfhi_after_reset_stalls", n, 0);

        // Randomized traffic over a small register window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            kind_t k;
            k = kind_t'($urandom_range(0, int'(K_NOP)));
            if ($urandom_range(0, 9) == 0) begin
                bit s;
                drive_cycle(encode(k, 1, 2, 3), 1'b0, props(K_NOP, 0, 0, 0), s);
            end else begin
                issue(k, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), n);
            end
        end
        idle(2);

`ifdef HAZARD_STATS_EN
        expect_dir("stall_cnt", stall_cnt, exp_stall_tot);
        expect_dir("mdu_stall_cnt", mdu_stall_cnt, exp_mdu_tot);
`endif
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
